// File: rtl/tristate_bus_arbiter_if.sv
// Arbitration signals shared by the requesters (slave side) and tristate_bus_arbiter (master side).
interface tristate_bus_arbiter_if #(
    parameter int N = 4
);
    logic [N-1:0]         req;
    logic [N-1:0]         gnt;
    logic [N-1:0]         oe;
    logic                 busy;
    logic [$clog2(N)-1:0] owner;

    modport master (input req, output gnt, output oe, output busy, output owner);
    modport slave  (output req, input gnt, input oe, input busy, input owner);
endinterface

// File: rtl/tristate_bus_arbiter.sv
// Round-robin owner selection for a shared tri-state bus, with a forced dead cycle between owners.
// Define ARB_TIMEOUT_EN to compile in MAXHOLD preemption of an owner while others wait.
module tristate_bus_arbiter #(
    parameter int N       = 4,
    parameter int MAXHOLD = 8
) (
    input logic                    clk,
    input logic                    rst,
    tristate_bus_arbiter_if.master bus
);
    localparam int OW = $clog2(N);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] TURN  = 2'd2;

    localparam logic [N-1:0] ONE = N'(1);

    if (N < 2 || N > 8 || MAXHOLD < 1 || MAXHOLD > 255) begin : g_bad_param
        $error("tristate_bus_arbiter: N must be 2..8 and MAXHOLD 1..255");
    end

    logic [1:0]    state;
    logic [N-1:0]  gnt_q;
    logic          busy_q;
    logic [OW-1:0] owner_q;
    logic [OW-1:0] ptr;
    logic [OW-1:0] winner;
    logic [OW-1:0] next_ptr;
    logic          any_req;
    logic          preempt;
    int            idx;

    // Search upward from ptr with wrap; walking offsets downward lets the nearest request win.
    always_comb begin
        winner = ptr;
        idx    = 0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N;
            if (bus.req[idx]) begin
                winner = OW'(idx);
            end
        end
        next_ptr = (winner == OW'(N - 1)) ? '0 : winner + 1'b1;
        any_req  = |bus.req;
    end

`ifdef ARB_TIMEOUT_EN
    localparam int HW = $clog2(MAXHOLD + 1);

    logic [HW-1:0] hold_cnt;
    logic [HW-1:0] hold_next;

    // Preempt once this grant cycle brings the saturating count to MAXHOLD while someone else waits.
    always_comb begin
        hold_next = (hold_cnt == HW'(MAXHOLD)) ? hold_cnt : hold_cnt + 1'b1;
        preempt   = (state == GRANT) && (|(bus.req & ~gnt_q)) && (hold_next == HW'(MAXHOLD));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_cnt <= '0;
        end else if (state == GRANT) begin
            hold_cnt <= hold_next;
        end else begin
            hold_cnt <= '0;
        end
    end
`else
    assign preempt = 1'b0;
`endif

    // IDLE and TURN arbitrate identically; leaving GRANT always passes through one empty TURN cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            gnt_q   <= '0;
            busy_q  <= 1'b0;
            owner_q <= '0;
            ptr     <= '0;
        end else begin
            case (state)
                IDLE, TURN: begin
                    if (any_req) begin
                        state   <= GRANT;
                        gnt_q   <= ONE << winner;
                        busy_q  <= 1'b1;
                        owner_q <= winner;
                        ptr     <= next_ptr;
                    end else begin
                        state  <= IDLE;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                GRANT: begin
                    if (!bus.req[owner_q] || preempt) begin
                        state  <= TURN;
                        gnt_q  <= '0;
                        busy_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    gnt_q  <= '0;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.gnt   = gnt_q;
    assign bus.oe    = gnt_q;
    assign bus.busy  = busy_q;
    assign bus.owner = owner_q;

endmodule

// File: tb/tb_tristate_bus_arbiter.sv
// Scoreboard bench for tristate_bus_arbiter: directed and random REQ patterns, checked against a
// cycle-level arbitration model; honours ARB_TIMEOUT_EN the same way the design does.
module tb_tristate_bus_arbiter;
    localparam int N       = 4;
    localparam int MAXHOLD = 3;
`ifdef ARB_TIMEOUT_EN
    localparam bit TIMEOUT_ON = 1'b1;
`else
    localparam bit TIMEOUT_ON = 1'b0;
`endif

    typedef struct {
        logic [N-1:0] gnt;
        logic         busy;
        int           owner;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t exp_q[$];

    bit   m_granting;
    int   m_owner;
    int   m_ptr;
    int   m_held;

    tristate_bus_arbiter_if #(.N(N)) bus_if ();

    tristate_bus_arbiter #(
        .N       (N),
        .MAXHOLD (MAXHOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    // Four bus drivers, each putting its own signature on the shared bus when enabled.
    tri [31:0] shared_bus;
    for (genvar g = 0; g < N; g++) begin : g_buf
        assign shared_bus = bus_if.oe[g] ? (32'hA000_0000 + 32'(g)) : 32'bz;
    end

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation ran past its time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_granting = 1'b0;
        m_owner    = 0;
        m_ptr      = 0;
        m_held     = 0;
    endtask

    // One clock of the arbitration rules: owners keep the bus until release or timeout, then the
    // bus sits empty for a cycle, and a free bus goes to the first requester at or after m_ptr.
    task automatic model_step(input logic [N-1:0] r);
        exp_t         e;
        logic [N-1:0] one = N'(1);
        if (m_granting) begin
            if (m_held < MAXHOLD) m_held++;
            if (!r[m_owner]) begin
                m_granting = 1'b0;
            end else if (TIMEOUT_ON && m_held >= MAXHOLD && (r & ~(one << m_owner)) != '0) begin
                m_granting = 1'b0;
            end
        end else if (r != '0) begin
            for (int k = 0; k < N; k++) begin
                int cand = (m_ptr + k) % N;
                if (r[cand]) begin
                    m_owner = cand;
                    break;
                end
            end
            m_ptr      = (m_owner + 1) % N;
            m_granting = 1'b1;
            m_held     = 0;
        end
        e.gnt   = m_granting ? (one << m_owner) : '0;
        e.busy  = m_granting;
        e.owner = m_owner;
        exp_q.push_back(e);
    endtask

    task automatic apply_stimulus(input logic [N-1:0] r);
        @(negedge clk);
        bus_if.req = r;
        model_step(r);
    endtask

    // Monitor: every cycle out of reset it checks bus safety and retires one expected response.
    logic [N-1:0] prev_oe = '0;
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (rst) begin
            prev_oe = '0;
        end else begin
            check_output("oe_onehot0", 32'($onehot0(bus_if.oe)), 32'd1);
            if (prev_oe != '0 && bus_if.oe != '0) begin
                check_output("owner_change_without_gap", 32'(bus_if.oe), 32'(prev_oe));
            end
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check_output("gnt", 32'(bus_if.gnt), 32'(e.gnt));
                check_output("oe", 32'(bus_if.oe), 32'(e.gnt));
                check_output("busy", 32'(bus_if.busy), 32'(e.busy));
                check_output("owner", 32'(bus_if.owner), 32'(e.owner));
                if (e.gnt != '0) begin
                    check_output("bus_value", shared_bus, 32'hA000_0000 + 32'(e.owner));
                end
            end
            prev_oe = bus_if.oe;
        end
    end

    initial begin
        logic [N-1:0] r;
        bus_if.req = '0;
        model_reset();

        repeat (2) @(posedge clk);
        #2;
        check_output("reset_gnt", 32'(bus_if.gnt), 32'd0);
        check_output("reset_oe", 32'(bus_if.oe), 32'd0);
        check_output("reset_busy", 32'(bus_if.busy), 32'd0);
        check_output("reset_owner", 32'(bus_if.owner), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] reset during an active grant");
        apply_stimulus(4'b0011);
        apply_stimulus(4'b0011);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check_output("async_reset_oe", 32'(bus_if.oe), 32'd0);
        check_output("async_reset_busy", 32'(bus_if.busy), 32'd0);
        bus_if.req = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        apply_stimulus(4'b0011);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        $display("[TB] round-robin with each owner releasing after two cycles");
        for (int i = 0; i < N; i++) begin
            apply_stimulus(4'b1111);
            apply_stimulus(4'b1111);
            apply_stimulus(4'b1111 & ~(4'b0001 << i));
        end
        apply_stimulus(4'b1111);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        $display("[TB] turnaround between overlapping requesters");
        apply_stimulus(4'b0010);
        apply_stimulus(4'b0110);
        apply_stimulus(4'b0100);
        apply_stimulus(4'b0100);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        $display("[TB] long hold with a second requester waiting");
        apply_stimulus(4'b0001);
        for (int i = 0; i < 10; i++) apply_stimulus(4'b0101);
        apply_stimulus(4'b0100);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        $display("[TB] lone owner for twenty cycles");
        for (int i = 0; i < 20; i++) apply_stimulus(4'b1000);
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        $display("[TB] random request traffic");
        r = '0;
        for (int i = 0; i < 400; i++) begin
            r = r ^ (N'($urandom) & N'($urandom));
            apply_stimulus(r);
        end
        apply_stimulus(4'b0000);
        apply_stimulus(4'b0000);

        @(posedge clk);
        #3;
        check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
